led_pwm_driver: RTL

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_prescaler.sv | 34 +++
 rtl/led_pwm_driver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM driver.
// Duty/phase width, the run-state enum and the PWM compare helper.
package led_pkg;

  // Duty and phase counter width; one PWM period is 2**DUTY_W ticks.
  localparam int DUTY_W = 5;

  // Last phase value of a period; the phase wraps to 0 after it.
  localparam logic [DUTY_W-1:0] PHASE_LAST = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // LED level for a given phase: lit while phase is below the duty.
  function automatic logic pwm_level(input logic [DUTY_W-1:0] phase,
                                     input logic [DUTY_W-1:0] duty);
    return (phase < duty);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Tick prescaler for the LED PWM driver.
// Counts 0..PRESCALE-1 while enabled and flags the last count as a tick.
// Holds the count at 0 whenever disabled so a restart always begins a
// full tick interval.
module led_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic tick_out
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == LAST);
  assign tick_out = en_in && w_last;

  // Free-running modulo-PRESCALE count, cleared by reset or disable.
  always_ff @(posedge clk_in) begin
    if (rst_in || !en_in) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver top.
// Two-state IDLE/RUN controller driving a 32-step PWM from a prescaled
// tick. Duty requests land in a pending register and are promoted to the
// active duty only at a period boundary (or while idle), so a period is
// never distorted by a mid-period update.
// Optional feature: define LED_PWM_BLINK_EN to add a blink gate that
// blanks the LED for BLINK_PERIODS periods after every BLINK_PERIODS lit
// periods. The port list is the same either way.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid_in,
  output logic              led_out,
  output logic              period_start_out
);

  state_t            r_state;
  logic [DUTY_W-1:0] r_phase;
  logic [DUTY_W-1:0] r_pending;
  logic [DUTY_W-1:0] r_active;
  logic              r_led;
  logic              r_pstart;

  logic w_run;
  logic w_tick;
  logic w_wrap;
  logic w_blink_off;

  // Counting only happens while running and still enabled; the edge that
  // sees en_in low already clears the counters.
  assign w_run  = (r_state == RUN) && en_in;
  assign w_wrap = w_tick && (r_phase == PHASE_LAST);

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (w_run),
    .tick_out (w_tick)
  );

  // Run-state controller with registered LED and period-start outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_led    <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_phase  <= '0;
          r_led    <= 1'b0;
          // The first RUN cycle is the first cycle of a period.
          r_pstart <= en_in;
          if (en_in) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!en_in) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_led    <= 1'b0;
            r_pstart <= 1'b0;
          end else begin
            if (w_tick) begin
              r_phase <= r_phase + DUTY_W'(1);
            end
            // Compare uses pre-edge phase/duty: one cycle of latency.
            r_led    <= pwm_level(r_phase, r_active) && !w_blink_off;
            r_pstart <= w_wrap;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_phase  <= '0;
          r_led    <= 1'b0;
          r_pstart <= 1'b0;
        end
      endcase
    end
  end

  // Pending duty tracks every request; active duty changes only at a
  // period boundary or while idle, taking a same-edge request first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      if (duty_valid_in) begin
        r_pending <= duty_in;
      end
      if ((r_state == IDLE) || w_wrap) begin
        r_active <= duty_valid_in ? duty_in : r_pending;
      end
    end
  end

`ifdef LED_PWM_BLINK_EN
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_ph;

  // Count completed periods; flip the blink phase every BLINK_PERIODS.
  always_ff @(posedge clk_in) begin
    if (rst_in || !w_run) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign w_blink_off = r_blink_ph;
`else
  // No blink gate: the mask is constant low whatever BLINK_PERIODS is.
  assign w_blink_off = 1'b0 && (BLINK_PERIODS > 0);
`endif

  assign led_out          = r_led;
  assign period_start_out = r_pstart;

endmodule
